// File: rtl/alu_core_seq.sv
// Sequential ALU with a synchronised "go" button: single-cycle bitwise/arith ops
// and a 2*WIDTH-cycle signed shift-add multiplier, results registered for display.
module alu_core_seq #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             go,
  output logic [WIDTH-1:0] sum,
  output logic             flow,
  output logic             carry,
  output logic             zero,
  output logic             valid,
  output logic             busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(PW) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_low_seen;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [2:0]             r_op;
  logic [PW-1:0]          r_mcand;
  logic [PW-1:0]          r_mplier;
  logic [PW-1:0]          r_prod;
  logic [CW-1:0]          r_cnt;

  logic                   w_sync_out;
  logic                   w_primed;
  logic                   w_start;
  logic [WIDTH:0]         w_add;
  logic [WIDTH:0]         w_sub;
  logic [WIDTH:0]         w_ptop;
  logic [WIDTH-1:0]       w_res;
  logic                   w_flow;
  logic                   w_carry;
  logic                   w_sa;
  logic                   w_sb;

  // A start needs a low level seen only after the chain refilled post-reset,
  // so a button held through reset does not fire on release.
  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_primed   = r_fill[SYNC_STAGES-1];
  assign w_start    = r_low_seen & w_sync_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync     <= '0;
      r_fill     <= '0;
      r_low_seen <= 1'b0;
    end else begin
      r_sync     <= (r_sync << 1) | SYNC_STAGES'(go);
      r_fill     <= (r_fill << 1) | SYNC_STAGES'(1'b1);
      r_low_seen <= w_primed & ~w_sync_out;
    end
  end

  assign w_sa   = r_a[WIDTH-1];
  assign w_sb   = r_b[WIDTH-1];
  assign w_add  = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub  = {1'b0, r_a} + {1'b0, ~r_b} + (WIDTH+1)'(1);
  assign w_ptop = r_prod[PW-1:WIDTH-1];

  // Result selection from the latched operands
  always_comb begin
    w_res   = '0;
    w_flow  = 1'b0;
    w_carry = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_flow  = (w_sa == w_sb) && (w_add[WIDTH-1] != w_sa);
      end
      OP_SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_flow  = (w_sa != w_sb) && (w_sub[WIDTH-1] != w_sa);
      end
      OP_NOT: w_res = ~r_a;
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_MUL: begin
        w_res  = r_prod[WIDTH-1:0];
        w_flow = ~((&w_ptop) | ~(|w_ptop));
      end
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      default: w_res = '0;
    endcase
  end

  // Control FSM, operand latches, shift-add multiplier and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      sum      <= '0;
      flow     <= 1'b0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a      <= a;
            r_b      <= b;
            r_op     <= op;
            r_mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
            r_mplier <= {{WIDTH{b[WIDTH-1]}}, b};
            r_prod   <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= (op == OP_MUL) ? S_MUL : S_DONE;
          end
        end
        S_MUL: begin
          if (r_mplier[0]) begin
            r_prod <= r_prod + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(PW - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          sum     <= w_res;
          flow    <= w_flow;
          carry   <= w_carry;
          zero    <= (w_res == '0);
          valid   <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_core_seq.sv
// Scoreboard bench for alu_core_seq: expected results queued at go, checked at valid.
module tb_alu_core_seq;

  localparam int unsigned W    = 4;
  localparam int unsigned SYNC = 2;
  localparam int          LAT_ALU = SYNC + 2;
  localparam int          LAT_MUL = SYNC + 2 * W + 2;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         flow;
    logic         carry;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         go;
  logic [W-1:0] sum;
  logic         flow;
  logic         carry;
  logic         zero;
  logic         valid;
  logic         busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t last_e;

  alu_core_seq #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .go(go),
    .sum(sum), .flow(flow), .carry(carry), .zero(zero),
    .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int sa, sb, ua, ub, r;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    ua = int'(av);
    ub = int'(bv);
    e = '0;
    case (o)
      3'b000: begin r = sa + sb; e.sum = W'(r); e.carry = ((ua + ub) >= 16);
                    e.flow = (r > 7) || (r < -8); end
      3'b001: begin r = sa - sb; e.sum = W'(r); e.carry = ((ua + (15 - ub) + 1) >= 16);
                    e.flow = (r > 7) || (r < -8); end
      3'b010: e.sum = ~av;
      3'b011: e.sum = av & bv;
      3'b100: e.sum = av | bv;
      3'b101: e.sum = av ^ bv;
      3'b110: begin r = sa * sb; e.sum = W'(r); e.flow = (r > 7) || (r < -8); end
      default: e.sum = (sa < sb) ? 4'd1 : 4'd0;
    endcase
    e.zero = (e.sum == '0);
    return e;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input exp_t e, input string name);
    int   got;
    int   lat;
    bit   busy_ok;
    exp_t want;
    exp_q.push_back(e);
    lat = (o == 3'b110) ? LAT_MUL : LAT_ALU;
    @(negedge clk);
    a = av; b = bv; op = o; go = 1'b1;
    got = 0;
    busy_ok = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 3) go = 1'b0;
      if (valid === 1'b1) begin got = cyc; break; end
      if (cyc > SYNC && busy !== 1'b1) busy_ok = 1'b0;
    end
    go = 1'b0;
    checks++;
    if (got != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, got, lat);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy: dropped before valid", name);
    end
    want = exp_q.pop_front();
    if (got != 0) begin
      checks++;
      if ({sum, flow, carry, zero} !== want) begin
        errors++;
        $display("FAIL %s result: got sum=%b flow=%b carry=%b zero=%b expected sum=%b flow=%b carry=%b zero=%b",
                 name, sum, flow, carry, zero, want.sum, want.flow, want.carry, want.zero);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_at_valid: got %b expected 0", name, busy);
      end
      @(negedge clk);
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL %s valid_pulse: got %b expected 0", name, valid);
      end
    end
    last_e = want;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; go = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sum, flow, carry, zero, valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: got sum=%b flow=%b carry=%b zero=%b valid=%b busy=%b expected all 0",
               sum, flow, carry, zero, valid, busy);
    end
    rst = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic test_arith();
    run_op(3'b000, 4'b0011, 4'b0100, '{4'b0111, 1'b0, 1'b0, 1'b0}, "add_basic");
    run_op(3'b000, 4'b0111, 4'b0001, '{4'b1000, 1'b1, 1'b0, 1'b0}, "add_ovf");
    run_op(3'b001, 4'b1000, 4'b0001, '{4'b0111, 1'b1, 1'b1, 1'b0}, "sub_ovf");
    run_op(3'b001, 4'b0011, 4'b0011, '{4'b0000, 1'b0, 1'b1, 1'b1}, "sub_zero");
    run_op(3'b000, 4'b1111, 4'b0001, '{4'b0000, 1'b0, 1'b1, 1'b1}, "add_carry");
  endtask

  task automatic test_logic();
    run_op(3'b010, 4'b0101, 4'b0000, '{4'b1010, 1'b0, 1'b0, 1'b0}, "not");
    run_op(3'b011, 4'b1100, 4'b1010, '{4'b1000, 1'b0, 1'b0, 1'b0}, "and");
    run_op(3'b100, 4'b1100, 4'b0011, '{4'b1111, 1'b0, 1'b0, 1'b0}, "or");
    run_op(3'b101, 4'b1010, 4'b1010, '{4'b0000, 1'b0, 1'b0, 1'b1}, "xor_zero");
    run_op(3'b111, 4'b1110, 4'b0001, '{4'b0001, 1'b0, 1'b0, 1'b0}, "slt_true");
    run_op(3'b111, 4'b0001, 4'b1110, '{4'b0000, 1'b0, 1'b0, 1'b1}, "slt_false");
  endtask

  task automatic test_mul();
    run_op(3'b110, 4'b0011, 4'b1110, '{4'b1010, 1'b0, 1'b0, 1'b0}, "mul_neg");
    run_op(3'b110, 4'b0011, 4'b0011, '{4'b1001, 1'b1, 1'b0, 1'b0}, "mul_ovf");
    run_op(3'b110, 4'b1000, 4'b1000, '{4'b0000, 1'b1, 1'b0, 1'b1}, "mul_min");
  endtask

  task automatic test_mul_mid_go();
    int   nvalid;
    exp_t want;
    exp_q.push_back('{4'b1001, 1'b1, 1'b0, 1'b0});
    nvalid = 0;
    @(negedge clk);
    a = 4'b0011; b = 4'b0011; op = 3'b110; go = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 3) go = 1'b0;
      if (cyc == 6) begin go = 1'b1; a = 4'b0001; b = 4'b0001; op = 3'b000; end
      if (cyc == 9) go = 1'b0;
      if (valid === 1'b1) nvalid++;
    end
    want = exp_q.pop_front();
    checks++;
    if (nvalid != 1) begin
      errors++;
      $display("FAIL mid_go_valid_count: got %0d expected 1", nvalid);
    end
    checks++;
    if ({sum, flow, carry, zero} !== want) begin
      errors++;
      $display("FAIL mid_go_result: got sum=%b flow=%b expected sum=%b flow=%b",
               sum, flow, want.sum, want.flow);
    end
    last_e = want;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    checks++;
    if ({sum, flow, carry, zero} !== last_e) begin
      errors++;
      $display("FAIL hold: got sum=%b flow=%b carry=%b zero=%b expected sum=%b flow=%b carry=%b zero=%b",
               sum, flow, carry, zero, last_e.sum, last_e.flow, last_e.carry, last_e.zero);
    end
  endtask

  task automatic test_reset_abort();
    int nvalid;
    @(negedge clk);
    a = 4'b0011; b = 4'b0011; op = 3'b110; go = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc == 3) go = 1'b0;
      if (cyc == 6) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL abort_busy_before: got %b expected 1", busy);
        end
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({sum, flow, carry, zero, valid, busy} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got sum=%b flow=%b carry=%b zero=%b valid=%b busy=%b expected all 0",
               sum, flow, carry, zero, valid, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nvalid = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL abort_no_valid: got %0d pulses expected 0", nvalid);
    end
    run_op(3'b000, 4'b0010, 4'b0011, '{4'b0101, 1'b0, 1'b0, 1'b0}, "add_after_abort");
  endtask

  task automatic test_go_held_reset();
    int nvalid;
    @(negedge clk);
    a = 4'b0001; b = 4'b0001; op = 3'b000; go = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nvalid = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (valid === 1'b1 || busy === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL held_go_start: got %0d active cycles expected 0", nvalid);
    end
    go = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    run_op(3'b001, 4'b0101, 4'b0111, '{4'b1110, 1'b0, 1'b0, 1'b0}, "sub_after_held");
  endtask

  task automatic test_back_to_back();
    logic [2:0]   o;
    logic [W-1:0] av, bv;
    for (int i = 0; i < 12; i++) begin
      o  = 3'($urandom_range(0, 7));
      av = W'($urandom);
      bv = W'($urandom);
      run_op(o, av, bv, model(o, av, bv), "random");
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_mul();
    test_mul_mid_go();
    test_hold();
    test_reset_abort();
    test_go_held_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_core_seq.md
ALU_CORE_SEQ -- requirements
Module: alu_core_seq

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4: operand and result width in bits.
REQ-002 The block SHALL take parameter SYNC_STAGES, default 2: number of synchroniser flops on go.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 a  input  WIDTH  operand A, two's complement, from switches.
REQ-006 b  input  WIDTH  operand B, two's complement, from switches.
REQ-007 op  input  3  opcode: 000 add, 001 sub, 010 not A, 011 and, 100 or, 101 xor, 110 signed mul, 111 signed less-than.
REQ-008 go  input  1  raw button level; asynchronous to clk.
REQ-009 sum  output  WIDTH  registered result for the seven-segment stage.
REQ-010 flow  output  1  registered signed-overflow flag.
REQ-011 carry  output  1  registered carry-out.
REQ-012 zero  output  1  registered flag, high when sum is all zeros.
REQ-013 valid  output  1  one-cycle pulse when a new result is loaded.
REQ-014 busy  output  1  high while an operation is in progress.

Function
REQ-015 go SHALL pass through SYNC_STAGES flops; a start event SHALL be a 0->1 transition at the synchroniser output.
REQ-016 The FSM SHALL have three states: IDLE, MUL and DONE.
REQ-017 In IDLE, a start event SHALL latch a, b and op into internal registers.
REQ-018 On that start, non-mul ops SHALL go to DONE; op 110 SHALL go to MUL.
REQ-019 Start events in MUL or DONE SHALL be ignored and SHALL NOT be queued.
REQ-020 busy SHALL be high in MUL and DONE and low in IDLE.
REQ-021 In DONE, sum, flow, carry and zero SHALL load together, valid SHALL be 1 for that cycle, and the FSM SHALL return to IDLE next cycle.
REQ-022 Non-mul latency SHALL be 2 cycles from the start-event edge to the valid pulse.
REQ-023 sum, flow, carry and zero SHALL hold between valid pulses, regardless of a, b, op or go.
REQ-024 Add SHALL compute sum = A+B mod 2^WIDTH, carry = bit WIDTH of the unsigned sum, flow = (A, B same sign) and (sum sign differs).
REQ-025 Sub SHALL compute A + ~B + 1, carry = carry-out of that addition, flow = (A, B signs differ) and (sum sign differs from A).
REQ-026 Ops not, and, or and xor SHALL be bitwise, with flow = 0 and carry = 0.
REQ-027 Less-than SHALL give sum = 1 when signed A < B, else 0, with flow = 0 and carry = 0.
REQ-028 Mul SHALL sign-extend A and B to 2*WIDTH bits and run shift-add for 2*WIDTH cycles in MUL, one partial product per cycle.
REQ-029 Mul SHALL enter DONE after the last iteration; start-to-valid latency SHALL be 2*WIDTH+2 cycles.
REQ-030 Mul SHALL output sum = product[WIDTH-1:0] and carry = 0.
REQ-031 Mul flow SHALL be 1 unless product[2*WIDTH-1:WIDTH-1] is all ones or all zeros.
REQ-032 zero SHALL be computed from the value being loaded into sum, not from the previous sum.
REQ-033 A start event and a change on a, b or op in the same cycle SHALL latch the new a, b and op values.

Reset
REQ-034 While rst is low: FSM = IDLE; sum = 0, flow = 0, carry = 0, zero = 0, valid = 0, busy = 0; synchroniser and latched-operand registers cleared.
REQ-035 Reset asserted during MUL or DONE SHALL abort the operation with no valid pulse.
REQ-036 After reset release, a go already held high SHALL NOT cause a start until it goes low and then high again.

Verification
REQ-037 add, a=0011, b=0100, go pulse -> valid 2 cycles after the sync edge; sum = 0111, flow = 0, carry = 0, zero = 0.
REQ-038 add, a=0111, b=0001 -> sum = 1000, flow = 1, carry = 0; then sub, a=1000, b=0001 -> sum = 0111, flow = 1, carry = 1.
REQ-039 xor, a=1010, b=1010 -> sum = 0000, zero = 1, flow = 0; less-than, a=1110, b=0001 -> sum = 0001.
REQ-040 mul, a=0011, b=1110 -> valid after 2*WIDTH+2 cycles with busy high throughout; sum = 1010, flow = 0.
REQ-041 mul, a=0011, b=0011 -> sum = 1001, flow = 1; a second go pulse mid-MUL gives exactly one valid and unchanged results.
REQ-042 rst low at MUL cycle 4 -> all outputs 0 immediately, no valid pulse; a new add after release completes normally.
